fl_checkpoint_ctrl: RTL and testbench

Branch checkpoint controller for the physical-register free list. It snapshots the free-list tail index when a branch dispatches, tracks up to NUM_BR in-flight branches with age dependencies, and sequences mispredict recovery. Recovery drives the free list's rollback enable/index and holds dispatch for a fixed recovery window. It sits between the decoder/dispatch stage, the branch-resolution path from execute, and the free-list rollback inputs.

---
 rtl/fl_checkpoint_ctrl.sv | 154 +++++++++++++++
 tb/tb_fl_checkpoint_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fl_checkpoint_ctrl.sv
// Branch checkpoint controller for the physical-register free list.
// Snapshots the free-list tail per in-flight branch and sequences mispredict rollback.
module fl_checkpoint_ctrl #(
    parameter  int unsigned NUM_FL         = 32,
    parameter  int unsigned NUM_BR         = 4,
    parameter  int unsigned RECOVER_CYCLES = 2,
    localparam int unsigned FL_IDX_W       = $clog2(NUM_FL),
    localparam int unsigned TAG_W          = $clog2(NUM_BR)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                dispatch_en,
    input  logic                dispatch_is_br,
    input  logic [FL_IDX_W-1:0] fl_tail_next,
    input  logic                br_resolve_en,
    input  logic [TAG_W-1:0]    br_resolve_tag,
    input  logic                br_mispredict,
    output logic                dispatch_stall,
    output logic [TAG_W-1:0]    br_tag_out,
    output logic                rollback_en,
    output logic [FL_IDX_W-1:0] rollback_idx,
    output logic [NUM_BR-1:0]   live_mask,
    output logic                busy
);

    localparam int unsigned CNT_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] RECOVER = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_BR-1:0]   live_q, live_d;
    logic [FL_IDX_W-1:0] snap_q  [NUM_BR];
    logic [FL_IDX_W-1:0] snap_d  [NUM_BR];
    logic [NUM_BR-1:0]   older_q [NUM_BR];
    logic [NUM_BR-1:0]   older_d [NUM_BR];
    logic                rb_en_d;
    logic [FL_IDX_W-1:0] rb_idx_d;

    logic [NUM_BR-1:0]   res_onehot;
    logic [NUM_BR-1:0]   ok_mask;
    logic [NUM_BR-1:0]   squash;
    logic                resolve_hit;
    logic                resolve_ok;
    logic                mispredict;
    logic                accept;
    logic                full;

    assign full        = &live_q;
    assign res_onehot  = NUM_BR'(1) << br_resolve_tag;
    assign resolve_hit = br_resolve_en & live_q[br_resolve_tag];
    assign resolve_ok  = resolve_hit & ~br_mispredict;
    assign mispredict  = resolve_hit & br_mispredict;
    assign ok_mask     = resolve_ok ? res_onehot : '0;

    assign dispatch_stall = (state_q != IDLE) | (dispatch_is_br & full);
    assign accept         = dispatch_en & dispatch_is_br & ~dispatch_stall & ~mispredict;
    assign live_mask      = live_q;
    assign busy           = (state_q == RECOVER);

    // Lowest free slot; scanning downward leaves the lowest clear index last.
    always_comb begin
        br_tag_out = '0;
        for (int i = int'(NUM_BR) - 1; i >= 0; i--) begin
            if (!live_q[i]) br_tag_out = TAG_W'(i);
        end
    end

    // The mispredicted slot plus every branch that recorded it as older.
    always_comb begin
        squash = res_onehot;
        for (int j = 0; j < int'(NUM_BR); j++) begin
            if (older_q[j][br_resolve_tag]) squash[j] = 1'b1;
        end
    end

    // Next-state: FSM, recovery counter, checkpoint table and rollback outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        live_d   = live_q;
        snap_d   = snap_q;
        older_d  = older_q;
        rb_en_d  = 1'b0;
        rb_idx_d = rollback_idx;

        if (resolve_ok) begin
            live_d = live_q & ~res_onehot;
            for (int k = 0; k < int'(NUM_BR); k++) begin
                older_d[k] = older_q[k] & ~res_onehot;
            end
        end

        if (mispredict) begin
            live_d   = live_q & ~squash;
            rb_en_d  = 1'b1;
            rb_idx_d = snap_q[br_resolve_tag];
        end

        if (accept) begin
            live_d[br_tag_out]  = 1'b1;
            snap_d[br_tag_out]  = fl_tail_next;
            older_d[br_tag_out] = live_q & ~ok_mask;
        end

        case (state_q)
            IDLE: begin
                if (mispredict) begin
                    state_d = RECOVER;
                    cnt_d   = CNT_W'(RECOVER_CYCLES - 1);
                end
            end
            RECOVER: begin
                if (mispredict) begin
                    cnt_d = CNT_W'(RECOVER_CYCLES - 1);
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            live_q       <= '0;
            rollback_en  <= 1'b0;
            rollback_idx <= '0;
            for (int k = 0; k < int'(NUM_BR); k++) begin
                snap_q[k]  <= '0;
                older_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            live_q       <= live_d;
            rollback_en  <= rb_en_d;
            rollback_idx <= rb_idx_d;
            for (int k = 0; k < int'(NUM_BR); k++) begin
                snap_q[k]  <= snap_d[k];
                older_q[k] <= older_d[k];
            end
        end
    end

endmodule

// File: tb/tb_fl_checkpoint_ctrl.sv
// Directed bench for fl_checkpoint_ctrl; rollback pulses are checked by a queue-based scoreboard.
module tb_fl_checkpoint_ctrl;

    localparam int unsigned NUM_FL   = 32;
    localparam int unsigned NUM_BR   = 4;
    localparam int unsigned FL_IDX_W = $clog2(NUM_FL);
    localparam int unsigned TAG_W    = $clog2(NUM_BR);

    logic                clock;
    logic                reset;
    logic                dispatch_en;
    logic                dispatch_is_br;
    logic [FL_IDX_W-1:0] fl_tail_next;
    logic                br_resolve_en;
    logic [TAG_W-1:0]    br_resolve_tag;
    logic                br_mispredict;
    logic                dispatch_stall;
    logic [TAG_W-1:0]    br_tag_out;
    logic                rollback_en;
    logic [FL_IDX_W-1:0] rollback_idx;
    logic [NUM_BR-1:0]   live_mask;
    logic                busy;

    int checks   = 0;
    int failures = 0;
    logic [FL_IDX_W-1:0] rb_q[$];

    fl_checkpoint_ctrl #(.NUM_FL(NUM_FL), .NUM_BR(NUM_BR), .RECOVER_CYCLES(2)) dut (
        .clock          (clock),
        .reset          (reset),
        .dispatch_en    (dispatch_en),
        .dispatch_is_br (dispatch_is_br),
        .fl_tail_next   (fl_tail_next),
        .br_resolve_en  (br_resolve_en),
        .br_resolve_tag (br_resolve_tag),
        .br_mispredict  (br_mispredict),
        .dispatch_stall (dispatch_stall),
        .br_tag_out     (br_tag_out),
        .rollback_en    (rollback_en),
        .rollback_idx   (rollback_idx),
        .live_mask      (live_mask),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        dispatch_en    = 1'b0;
        dispatch_is_br = 1'b0;
        fl_tail_next   = '0;
        br_resolve_en  = 1'b0;
        br_resolve_tag = '0;
        br_mispredict  = 1'b0;
    endtask

    task automatic drive_branch(input int tail);
        dispatch_en    = 1'b1;
        dispatch_is_br = 1'b1;
        fl_tail_next   = FL_IDX_W'(tail);
    endtask

    task automatic drive_resolve(input int tag, input logic mis);
        br_resolve_en  = 1'b1;
        br_resolve_tag = TAG_W'(tag);
        br_mispredict  = mis;
    endtask

    // Scoreboard monitor: every rollback pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        if (rollback_en === 1'b1) begin
            if (rb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rollback actual idx=%0d expected no pulse t=%0t", rollback_idx, $time);
            end else begin
                chk("rollback_idx", 32'(rollback_idx), 32'(rb_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_live", 32'(live_mask), 32'h0);
        chk("rst_stall", 32'(dispatch_stall), 32'h0);
        chk("rst_rb_en", 32'(rollback_en), 32'h0);
        chk("rst_tag", 32'(br_tag_out), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // Fill all four slots with tails 5..8.
        for (int i = 0; i < 4; i++) begin
            drive_branch(5 + i);
            #1;
            chk("alloc_tag", 32'(br_tag_out), 32'(i));
            chk("alloc_stall", 32'(dispatch_stall), 32'h0);
            tick();
        end
        #1;
        chk("full_live", 32'(live_mask), 32'hf);
        chk("full_br_stall", 32'(dispatch_stall), 32'h1);
        dispatch_is_br = 1'b0;
        #1;
        chk("full_nonbr_stall", 32'(dispatch_stall), 32'h0);
        tick();
        idle_inputs();
        #1;
        chk("nonbr_no_alloc", 32'(live_mask), 32'hf);

        // Mispredict tag 1: squashes 1,2,3 and restores tail 6.
        drive_resolve(1, 1'b1);
        rb_q.push_back(FL_IDX_W'(6));
        tick();
        idle_inputs();
        #1;
        chk("mis1_live", 32'(live_mask), 32'h1);
        chk("mis1_stall_c1", 32'(dispatch_stall), 32'h1);
        chk("mis1_busy", 32'(busy), 32'h1);
        tick();
        #1;
        chk("mis1_stall_c2", 32'(dispatch_stall), 32'h1);
        tick();
        #1;
        chk("mis1_stall_end", 32'(dispatch_stall), 32'h0);
        chk("mis1_busy_end", 32'(busy), 32'h0);

        // Tag 1 (tail 9), then tag 2 (tail 10) alongside a correct resolve of tag 0.
        drive_branch(9);
        #1;
        chk("realloc_tag1", 32'(br_tag_out), 32'h1);
        tick();
        drive_branch(10);
        drive_resolve(0, 1'b0);
        #1;
        chk("alloc_tag2", 32'(br_tag_out), 32'h2);
        tick();
        idle_inputs();
        #1;
        chk("ok_res_live", 32'(live_mask), 32'h6);

        // Mispredict on non-live tag 0 has no effect.
        drive_resolve(0, 1'b1);
        tick();
        idle_inputs();
        #1;
        chk("dead_mis_live", 32'(live_mask), 32'h6);
        chk("dead_mis_busy", 32'(busy), 32'h0);

        // Re-allocate slot 0 (tail 11) and mispredict it; slot 2 must survive.
        drive_branch(11);
        #1;
        chk("realloc_tag0", 32'(br_tag_out), 32'h0);
        tick();
        idle_inputs();
        drive_resolve(0, 1'b1);
        rb_q.push_back(FL_IDX_W'(11));
        tick();
        idle_inputs();
        #1;
        chk("older_excl_live", 32'(live_mask), 32'h6);
        tick();
        tick();
        #1;
        chk("mis0_stall_end", 32'(dispatch_stall), 32'h0);

        // Mispredict tag 2 with a simultaneous branch dispatch: no allocation.
        drive_branch(20);
        drive_resolve(2, 1'b1);
        rb_q.push_back(FL_IDX_W'(10));
        tick();
        idle_inputs();
        #1;
        chk("mis_disp_live", 32'(live_mask), 32'h2);
        tick();
        tick();
        #1;
        chk("mis2_stall_end", 32'(dispatch_stall), 32'h0);

        // Tag 0 tail 3, tag 2 tail 4; mispredict 2 then older 0 during recovery.
        drive_branch(3);
        #1;
        chk("alloc_t0_snap3", 32'(br_tag_out), 32'h0);
        tick();
        drive_branch(4);
        #1;
        chk("alloc_t2_snap4", 32'(br_tag_out), 32'h2);
        tick();
        idle_inputs();
        #1;
        chk("pre_nested_live", 32'(live_mask), 32'h7);
        drive_resolve(2, 1'b1);
        rb_q.push_back(FL_IDX_W'(4));
        tick();
        drive_resolve(0, 1'b1);
        rb_q.push_back(FL_IDX_W'(3));
        #1;
        chk("nested_stall_c1", 32'(dispatch_stall), 32'h1);
        chk("nested_live_c1", 32'(live_mask), 32'h3);
        tick();
        idle_inputs();
        #1;
        chk("nested_live", 32'(live_mask), 32'h2);
        chk("nested_stall_r1", 32'(dispatch_stall), 32'h1);
        chk("nested_busy", 32'(busy), 32'h1);
        tick();
        #1;
        chk("nested_stall_r2", 32'(dispatch_stall), 32'h1);
        tick();
        #1;
        chk("nested_stall_end", 32'(dispatch_stall), 32'h0);

        // Reset in the middle of recovery.
        drive_resolve(1, 1'b1);
        rb_q.push_back(FL_IDX_W'(9));
        tick();
        idle_inputs();
        reset = 1'b1;
        #1;
        chk("pre_rst_busy", 32'(busy), 32'h1);
        tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_live", 32'(live_mask), 32'h0);
        chk("mid_rst_stall", 32'(dispatch_stall), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_rb_en", 32'(rollback_en), 32'h0);
        chk("mid_rst_rb_idx", 32'(rollback_idx), 32'h0);
        chk("mid_rst_tag", 32'(br_tag_out), 32'h0);

        tick();
        tick();
        chk("rb_queue_drained", 32'(rb_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
